// File: rtl/out_neu_array.sv
// Output spiking-neuron layer: N leaky integrate-and-fire neurons updated one per cycle, with k-winner lateral inhibition.
// Optional refractory counters are enabled with macro OUT_NEU_REFRAC_EN.
module out_neu_array #(
  parameter int N    = 8,
  parameter int W    = 24,
  parameter int TH   = 15018,
  parameter int D    = 614,
  parameter int PRES = 0,
  parameter int PMIN = -2048000,
  parameter int REF  = 30,
  parameter int KWIN = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_img,
  input  logic           start_step,
  input  logic           isor,
  input  logic [N*W-1:0] syn_cur,
  output logic           busy,
  output logic           valid,
  output logic [N-1:0]   spike_out,
  output logic           first_spike,
  output logic           li_done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = W + 2;
  localparam int KW = $clog2(KWIN + 1);
  localparam logic signed [XW-1:0] SMAX  = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] PMINX = XW'(PMIN);
  localparam logic signed [XW-1:0] DX    = XW'(D);
  localparam logic signed [W-1:0]  THW   = W'(TH);
  localparam logic signed [W-1:0]  PRESW = W'(PRES);
  localparam logic signed [W-1:0]  PMINW = W'(PMIN);

  typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_SELECT, S_APPLY, S_DONE} state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic signed [W-1:0]   r_pot [N];
  logic [N-1:0]          r_cand;
  logic [N-1:0]          r_win;
  logic [N-1:0]          r_fire;
  logic signed [W-1:0]   r_best;
  logic [IW-1:0]         r_bidx;
  logic                  r_have;
  logic [KW-1:0]         r_nwin;
`ifdef OUT_NEU_REFRAC_EN
  localparam int RW = (REF > 0) ? $clog2(REF + 1) : 1;
  logic [RW-1:0]         r_ref [N];
`endif

  logic signed [W-1:0]   w_cur_arr [N];
  logic signed [W-1:0]   w_pot;
  logic signed [W-1:0]   w_cur;
  logic signed [XW-1:0]  w_sum;
  logic signed [W-1:0]   w_next;
  logic                  w_refr;
  logic                  w_is_cand;
  logic                  w_last;
  logic                  w_take;
  logic                  w_found;
  logic [IW-1:0]         w_widx;
  logic [N-1:0]          w_fire;

  // Clamp the widened sum back into the potential range [PMIN, 2^(W-1)-1].
  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] x);
    if (x > SMAX)
      sat = SMAX[W-1:0];
    else if (x < PMINX)
      sat = PMINX[W-1:0];
    else
      sat = x[W-1:0];
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_cur
    assign w_cur_arr[g] = syn_cur[g*W +: W];
  end

  always_comb begin
    w_pot     = r_pot[r_idx];
    w_cur     = w_cur_arr[r_idx];
    w_sum     = XW'(w_pot) - DX + (isor ? XW'(w_cur) : '0);
    w_next    = sat(w_sum);
    w_refr    = 1'b0;
`ifdef OUT_NEU_REFRAC_EN
    w_refr    = (r_ref[r_idx] != '0);
`endif
    w_is_cand = !w_refr && (w_next >= THW);
    w_last    = (r_idx == IW'(N - 1));
    // Strict greater-than keeps the lowest index on equal potentials.
    w_take    = r_cand[r_idx] && !r_win[r_idx] && (!r_have || (w_pot > r_best));
    w_found   = w_take || r_have;
    w_widx    = w_take ? r_idx : r_bidx;
    w_fire    = li_done ? r_cand : r_win;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      spike_out   <= '0;
      first_spike <= 1'b0;
      li_done     <= 1'b0;
      r_cand      <= '0;
      r_win       <= '0;
      r_fire      <= '0;
      r_best      <= '0;
      r_bidx      <= '0;
      r_have      <= 1'b0;
      r_nwin      <= '0;
      for (int i = 0; i < N; i++) begin
        r_pot[i] <= PRESW;
`ifdef OUT_NEU_REFRAC_EN
        r_ref[i] <= '0;
`endif
      end
    end else if (start_img) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      spike_out   <= '0;
      first_spike <= 1'b0;
      li_done     <= 1'b0;
      r_cand      <= '0;
      r_win       <= '0;
      r_have      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_pot[i] <= PRESW;
`ifdef OUT_NEU_REFRAC_EN
        r_ref[i] <= '0;
`endif
      end
    end else begin
      valid       <= 1'b0;
      first_spike <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_step) begin
            r_state <= S_UPDATE;
            r_idx   <= '0;
            busy    <= 1'b1;
            r_cand  <= '0;
            r_win   <= '0;
          end
        end
        // UPDATE: one neuron per cycle through the shared adder
        S_UPDATE: begin
          if (w_refr) begin
`ifdef OUT_NEU_REFRAC_EN
            r_ref[r_idx] <= r_ref[r_idx] - 1'b1;
`endif
          end else begin
            r_pot[r_idx]  <= w_next;
            r_cand[r_idx] <= w_is_cand;
          end
          if (w_last) begin
            r_idx   <= '0;
            r_have  <= 1'b0;
            r_nwin  <= '0;
            r_state <= (((r_cand == '0) && !w_is_cand) || li_done) ? S_APPLY : S_SELECT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        // SELECT: each pass scans all neurons for the strongest unpicked candidate
        S_SELECT: begin
          if (w_take) begin
            r_best <= w_pot;
            r_bidx <= r_idx;
            r_have <= 1'b1;
          end
          if (w_last) begin
            r_idx  <= '0;
            r_have <= 1'b0;
            if (w_found) begin
              r_win[w_widx] <= 1'b1;
              r_nwin        <= r_nwin + 1'b1;
              r_state       <= (r_nwin == KW'(KWIN - 1)) ? S_APPLY : S_SELECT;
            end else begin
              r_state <= S_APPLY;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        // APPLY: reset firing neurons, inhibit the rest before the first image spike
        S_APPLY: begin
          r_fire <= w_fire;
          for (int i = 0; i < N; i++) begin
            if (w_fire[i]) begin
              r_pot[i] <= PRESW;
`ifdef OUT_NEU_REFRAC_EN
              r_ref[i] <= RW'(REF);
`endif
            end else if (!li_done && (|w_fire)) begin
              r_pot[i] <= PMINW;
            end
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          valid       <= 1'b1;
          busy        <= 1'b0;
          spike_out   <= r_fire;
          first_spike <= (|r_fire) && !li_done;
          li_done     <= li_done | (|r_fire);
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_neu_array.sv
// Directed bench for out_neu_array: leak, inhibition, ties, post-spike firing, refractory, reset and abort.
module tb_out_neu_array;
  localparam int N = 8;
  localparam int W = 24;
  localparam int PMIN = -2048000;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_img;
  logic           start_step;
  logic           isor;
  logic [N*W-1:0] syn_cur;
  logic           busy;
  logic           valid;
  logic [N-1:0]   spike_out;
  logic           first_spike;
  logic           li_done;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic seen_valid;

  always #5 clk = ~clk;

  out_neu_array #(
    .N(N), .W(W), .TH(15018), .D(614), .PRES(0), .PMIN(PMIN), .REF(2), .KWIN(1)
  ) dut (
    .clk(clk), .rst(rst), .start_img(start_img), .start_step(start_step), .isor(isor),
    .syn_cur(syn_cur), .busy(busy), .valid(valid), .spike_out(spike_out),
    .first_spike(first_spike), .li_done(li_done)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pot(input int i, input logic signed [63:0] exp);
    chk($sformatf("pot%0d", i), dut.r_pot[i], exp);
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < N; i++) syn_cur[i*W +: W] = v[W-1:0];
  endtask

  task automatic set_one(input int i, input int v);
    syn_cur[i*W +: W] = v[W-1:0];
  endtask

  task automatic pulse_img();
    @(negedge clk); start_img = 1'b1;
    @(negedge clk); start_img = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk); start_step = 1'b1;
    @(posedge clk); #1 start_step = 1'b0;
  endtask

  // Counts clock edges after the accept edge until valid is seen; -1 on timeout.
  task automatic wait_valid(output int l);
    l = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic do_step(output int l);
    pulse_step();
    wait_valid(l);
  endtask

  initial begin
    rst = 1'b0; start_img = 1'b0; start_step = 1'b0; isor = 1'b0; syn_cur = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_spike", spike_out, 0);
    chk("rst_first", first_spike, 0);
    chk("rst_lidone", li_done, 0);
    chk_pot(0, 0);
    @(negedge clk) rst = 1'b1;

    // Plain leak
    do_step(lat);
    chk("leak_lat", lat, 10);
    chk("leak_spike", spike_out, 0);
    chk("leak_first", first_spike, 0);
    chk("leak_lidone", li_done, 0);
    chk("leak_busy", busy, 0);
    for (int i = 0; i < N; i++) chk_pot(i, -614);
    @(posedge clk); #1;
    chk("leak_valid_pulse", valid, 0);

    // Single winner with inhibition
    pulse_img();
    isor = 1'b1; set_all(100); set_one(3, 16000);
    do_step(lat);
    chk("win_lat", lat, 18);
    chk("win_spike", spike_out, 8'h08);
    chk("win_first", first_spike, 1);
    chk("win_lidone", li_done, 1);
    chk_pot(3, 0);
    chk_pot(0, PMIN);
    chk_pot(7, PMIN);
    @(posedge clk); #1;
    chk("win_valid_pulse", valid, 0);
    chk("win_first_pulse", first_spike, 0);
    chk("win_spike_hold", spike_out, 8'h08);

    // Tie goes to the lower index
    pulse_img();
    chk("img_lidone", li_done, 0);
    chk("img_spike", spike_out, 0);
    chk_pot(0, 0);
    set_all(0); set_one(2, 16000); set_one(5, 16000);
    do_step(lat);
    chk("tie_lat", lat, 18);
    chk("tie_spike", spike_out, 8'h04);
    chk_pot(2, 0);
    chk_pot(5, PMIN);

    // Recharge 1 and 6 from PMIN to zero without firing
    set_all(0); set_one(1, 2048614); set_one(6, 2048614);
    do_step(lat);
    chk("chg_lat", lat, 10);
    chk("chg_spike", spike_out, 0);
    chk_pot(1, 0);
    chk_pot(2, -614);

    // After first spike: all candidates fire, no inhibition, no SELECT
    set_one(1, 16000); set_one(6, 16000);
    do_step(lat);
    chk("post_lat", lat, 10);
    chk("post_spike", spike_out, 8'h42);
    chk("post_first", first_spike, 0);
    chk("post_lidone", li_done, 1);
    chk_pot(1, 0);
    chk_pot(6, 0);
    chk_pot(2, -1228);
    chk_pot(0, PMIN);

    // Refractory behaviour (or continuous integration when disabled)
    pulse_img();
    set_all(100); set_one(3, 16000);
    do_step(lat);
    chk("ref0_spike", spike_out, 8'h08);
`ifdef OUT_NEU_REFRAC_EN
    do_step(lat);
    chk("ref1_lat", lat, 10);
    chk("ref1_spike", spike_out, 8'h00);
    chk_pot(3, 0);
    do_step(lat);
    chk("ref2_spike", spike_out, 8'h00);
    do_step(lat);
    chk("ref3_spike", spike_out, 8'h08);
`else
    do_step(lat);
    chk("noref_lat", lat, 10);
    chk("noref_spike", spike_out, 8'h08);
`endif

    // Asynchronous reset in UPDATE cycle 4
    pulse_step();
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    chk("arst_spike", spike_out, 0);
    chk("arst_first", first_spike, 0);
    chk("arst_lidone", li_done, 0);
    chk_pot(0, 0);
    @(negedge clk); rst = 1'b1; start_step = 1'b1;
    @(posedge clk); #1 start_step = 1'b0;
    chk("arst_accept", busy, 1);
    wait_valid(lat);
    chk("arst_lat", lat, 18);
    chk("arst_step_spike", spike_out, 8'h08);

    // start_img during SELECT aborts without valid
    pulse_img();
    pulse_step();
    repeat (10) @(posedge clk);
    @(negedge clk); start_img = 1'b1;
    @(negedge clk); start_img = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (valid) seen_valid = 1'b1;
    end
    chk("abort_novalid", seen_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lidone", li_done, 0);
    chk("abort_spike", spike_out, 0);
    chk_pot(3, 0);

    // start_img and start_step together: step not accepted
    @(negedge clk); start_img = 1'b1; start_step = 1'b1;
    @(negedge clk); start_img = 1'b0; start_step = 1'b0;
    @(posedge clk); #1;
    chk("both_busy", busy, 0);
    do_step(lat);
    chk("both_relat", lat, 18);
    chk("both_spike", spike_out, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
